ppu_px_capture: RTL and testbench

- Sink end of the PPU pixel stream: consumes 2-bit pixels (PX_OUT/PX_valid) plus PPU mode.
- Tracks screen x/y and packs 4 pixels per byte.
- Writes packed bytes into a (optionally double-buffered) framebuffer RAM that the video scan-out side reads.
- Flags malformed lines/frames so PPU timing bugs are visible in simulation and on hardware.

---
 rtl/ppu_pkg.sv | 25 ++
 rtl/ppu_px_capture_if.sv | 27 ++
 rtl/ppu_px_capture_packer.sv | 52 +++++
 rtl/ppu_px_capture.sv | 123 ++++++++++++
 tb/tb_ppu_px_capture.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: mode encoding, screen geometry and framebuffer byte addressing.
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_STATES_t;

    typedef enum logic {
        CAP_OFF     = 1'b0,
        CAP_CAPTURE = 1'b1
    } cap_state_t;

    localparam int H_PIX_C           = 160;
    localparam int V_PIX_C           = 144;
    localparam int FB_BYTES_PER_LINE = 40;

    // line*40 + col/4, with the multiply split into two shifts so no multiplier is inferred.
    function automatic logic [12:0] fb_byte_addr(input logic [7:0] line, input logic [7:0] col);
        return {line, 5'b0} + {2'b0, line, 3'b0} + {7'b0, col[7:2]};
    endfunction

endpackage

// File: rtl/ppu_px_capture_if.sv
// Pixel-stream input and framebuffer/status output bundle of the PPU pixel capture block.
interface ppu_px_capture_if;

    logic        LCD_EN;
    logic [1:0]  PPU_MODE;
    logic [1:0]  PX_IN;
    logic        PX_valid;

    logic        FB_WE;
    logic [13:0] FB_ADDR;
    logic [7:0]  FB_DATA;
    logic        FB_DISP_BANK;
    logic        FRAME_DONE;
    logic        ERR_SHORT;
    logic        ERR_LONG;

    modport master (
        output LCD_EN, PPU_MODE, PX_IN, PX_valid,
        input  FB_WE, FB_ADDR, FB_DATA, FB_DISP_BANK, FRAME_DONE, ERR_SHORT, ERR_LONG
    );

    modport slave (
        input  LCD_EN, PPU_MODE, PX_IN, PX_valid,
        output FB_WE, FB_ADDR, FB_DATA, FB_DISP_BANK, FRAME_DONE, ERR_SHORT, ERR_LONG
    );

endinterface

// File: rtl/ppu_px_capture_packer.sv
// Packs four 2-bit pixels into a byte (leftmost pixel in [7:6]); a flush emits a partial
// byte with the unfilled slots left at 00. The emitted byte appears one cycle later with done.
module px_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       accept,
    input  logic [1:0] slot,
    input  logic [1:0] px,
    input  logic       flush,
    output logic       emit,
    output logic       done,
    output logic [7:0] data
);

    logic [7:0] pack;
    logic [7:0] pack_next;

    always_comb begin
        pack_next = pack;
        if (accept) begin
            case (slot)
                2'd0:    pack_next[7:6] = px;
                2'd1:    pack_next[5:4] = px;
                2'd2:    pack_next[3:2] = px;
                default: pack_next[1:0] = px;
            endcase
        end
    end

    assign emit = (accept && (slot == 2'd3)) || flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack <= '0;
            done <= 1'b0;
            data <= '0;
        end else if (clear) begin
            pack <= '0;
            done <= 1'b0;
        end else begin
            done <= emit;
            if (emit) begin
                data <= pack_next;
                pack <= '0;
            end else begin
                pack <= pack_next;
            end
        end
    end

endmodule

// File: rtl/ppu_px_capture.sv
// Sink of the PPU pixel stream: tracks screen x/y, packs pixels into bytes and writes them
// into a (optionally double-buffered) framebuffer, flagging short and overlong lines.
module ppu_px_capture
    import ppu_pkg::*;
#(
    parameter int H_PIX      = H_PIX_C,
    parameter int V_PIX      = V_PIX_C,
    parameter int DOUBLE_BUF = 1
) (
    input logic              clk,
    input logic              rst,
    ppu_px_capture_if.slave  bus
);

    localparam logic [7:0] H_LIM = 8'(H_PIX);
    localparam logic [7:0] V_LIM = 8'(V_PIX);

    cap_state_t  state;
    PPU_STATES_t mode;
    PPU_STATES_t prev_mode;

    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] x_acc;
    logic [7:0] y_line;
    logic       wbank;

    logic active;
    logic px_req;
    logic in_range;
    logic accept;
    logic drop;
    logic line_close;
    logic frame_close;
    logic flush;
    logic emit;
    logic pk_done;
    logic [7:0] pk_data;

    // LCD_EN low acts immediately, so the cycle it drops already behaves as OFF.
    assign mode        = PPU_STATES_t'(bus.PPU_MODE);
    assign active      = (state == CAP_CAPTURE) && bus.LCD_EN;
    assign px_req      = active && bus.PX_valid && (mode == DRAW);
    assign in_range    = (x < H_LIM) && (y < V_LIM);
    assign accept      = px_req && in_range;
    assign drop        = px_req && !in_range;
    assign line_close  = active && (prev_mode == DRAW) && (mode != DRAW);
    assign frame_close = active && (prev_mode != V_BLANK) && (mode == V_BLANK);

    assign x_acc  = accept ? (x + 8'd1) : x;
    assign y_line = (y < V_LIM) ? (y + 8'd1) : y;
    assign flush  = line_close && (x_acc[1:0] != 2'd0);

    px_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!active),
        .accept (accept),
        .slot   (x[1:0]),
        .px     (bus.PX_IN),
        .flush  (flush),
        .emit   (emit),
        .done   (pk_done),
        .data   (pk_data)
    );

    assign bus.FB_WE   = pk_done;
    assign bus.FB_DATA = pk_data;

    // x>>2 before the accept is the right byte index for both a full byte and a partial flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= CAP_OFF;
            prev_mode        <= H_BLANK;
            x                <= '0;
            y                <= '0;
            wbank            <= 1'b0;
            bus.FB_ADDR      <= '0;
            bus.FB_DISP_BANK <= 1'b0;
            bus.FRAME_DONE   <= 1'b0;
            bus.ERR_SHORT    <= 1'b0;
            bus.ERR_LONG     <= 1'b0;
        end else begin
            bus.FRAME_DONE <= 1'b0;
            prev_mode      <= mode;
            if (!bus.LCD_EN) begin
                state <= CAP_OFF;
                x     <= '0;
                y     <= '0;
            end else if (state == CAP_OFF) begin
                state <= CAP_CAPTURE;
                x     <= '0;
                y     <= '0;
            end else begin
                x <= x_acc;
                if (drop) begin
                    bus.ERR_LONG <= 1'b1;
                end
                if (emit) begin
                    bus.FB_ADDR <= {wbank, fb_byte_addr(y, x)};
                end
                if (line_close) begin
                    if (x_acc < H_LIM) begin
                        bus.ERR_SHORT <= 1'b1;
                    end
                    x <= '0;
                    y <= y_line;
                end
                // Frame close overrides the line-close y update; the flush above keeps the old bank.
                if (frame_close) begin
                    bus.FRAME_DONE   <= 1'b1;
                    bus.FB_DISP_BANK <= wbank;
                    if (DOUBLE_BUF != 0) begin
                        wbank <= ~wbank;
                    end
                    x <= '0;
                    y <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ppu_px_capture.sv
// Randomised bench for ppu_px_capture: a line-level framebuffer model predicts every write,
// frame pulse and error flag, and the observed stream is compared against it.
`timescale 1ns/1ps
module tb_ppu_px_capture;
    import ppu_pkg::*;

    typedef struct {
        int          cyc;
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   lastCyc = 0;
    int   checkCount = 0;
    int   passCount = 0;

    int   mx, my;
    bit   mwbank, mdisp, mErrShort, mErrLong;
    int   linePix[H_PIX_C];
    int   pixCyc[H_PIX_C];
    wr_t  expQ[$];
    wr_t  actQ[$];
    int   expFrame[$];
    int   actFrame[$];

    ppu_px_capture_if bus();

    ppu_px_capture #(
        .H_PIX      (H_PIX_C),
        .V_PIX      (V_PIX_C),
        .DOUBLE_BUF (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.FB_WE) actQ.push_back('{cyc, bus.FB_ADDR, bus.FB_DATA});
            if (bus.FRAME_DONE) actFrame.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checkCount++;
        if (got === want) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    endtask

    task automatic applyStimulus(input bit en, input logic [1:0] mode, input bit valid, input logic [1:0] px);
        bus.LCD_EN   = en;
        bus.PPU_MODE = mode;
        bus.PX_valid = valid;
        bus.PX_IN    = px;
        lastCyc      = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mx = 0; my = 0; mwbank = 0; mdisp = 0; mErrShort = 0; mErrLong = 0;
        expQ.delete(); actQ.delete(); expFrame.delete(); actFrame.delete();
    endtask

    task automatic modelPixel(input logic [1:0] p, input int c);
        if (mx < H_PIX_C && my < V_PIX_C) begin
            linePix[mx] = int'(p);
            pixCyc[mx]  = c;
            mx++;
        end else begin
            mErrLong = 1;
        end
    endtask

    task automatic pushByte(input int k, input int c);
        logic [7:0] d;
        wr_t w;
        d = 8'h00;
        for (int j = 0; j < 4; j++)
            if (4 * k + j < mx) d = d | 8'(linePix[4 * k + j] << (6 - 2 * j));
        w.cyc  = c;
        w.addr = {mwbank, 13'(my * FB_BYTES_PER_LINE + k)};
        w.data = d;
        expQ.push_back(w);
    endtask

    task automatic modelEmit(input bit partial, input int closeC);
        int nfull;
        nfull = mx / 4;
        for (int k = 0; k < nfull; k++) pushByte(k, pixCyc[4 * k + 3] + 1);
        if (partial && (mx % 4) != 0) pushByte(nfull, closeC + 1);
    endtask

    task automatic modelLineClose(input int c);
        modelEmit(1, c);
        if (mx < H_PIX_C) mErrShort = 1;
        mx = 0;
        if (my < V_PIX_C) my++;
    endtask

    task automatic modelFrameClose(input int c);
        expFrame.push_back(c + 1);
        mdisp  = mwbank;
        mwbank = ~mwbank;
        mx = 0;
        my = 0;
    endtask

    // pxSel: 0 = repeating 0,1,2,3; 1 = all 3; otherwise random colours.
    task automatic runLine(input int n, input int pxSel, input int gapPct, input logic [1:0] closeMode);
        for (int i = 0; i < n; i++) begin
            logic [1:0] p;
            if ($urandom_range(99) < gapPct) applyStimulus(1, DRAW, 0, 2'($urandom));
            case (pxSel)
                0:       p = 2'(i % 4);
                1:       p = 2'd3;
                default: p = 2'($urandom);
            endcase
            applyStimulus(1, DRAW, 1, p);
            modelPixel(p, lastCyc);
        end
        applyStimulus(1, closeMode, 0, 2'd0);
        modelLineClose(lastCyc);
        if (closeMode == V_BLANK) modelFrameClose(lastCyc);
        applyStimulus(1, closeMode, 0, 2'd0);
        applyStimulus(1, SCAN, 0, 2'd0);
    endtask

    task automatic endFrame();
        applyStimulus(1, V_BLANK, 0, 2'd0);
        modelFrameClose(lastCyc);
        repeat (2) applyStimulus(1, V_BLANK, 0, 2'd0);
        applyStimulus(1, SCAN, 0, 2'd0);
    endtask

    task automatic settle();
        repeat (3) applyStimulus(bus.LCD_EN, bus.PPU_MODE, 0, 2'd0);
    endtask

    task automatic compareAll(input string phase);
        int n;
        checkOutput({phase, ":wrCount"}, actQ.size(), expQ.size());
        n = (actQ.size() < expQ.size()) ? actQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({phase, ":wrAddr"}, 32'(actQ[i].addr), 32'(expQ[i].addr));
            checkOutput({phase, ":wrData"}, 32'(actQ[i].data), 32'(expQ[i].data));
            checkOutput({phase, ":wrCycle"}, actQ[i].cyc, expQ[i].cyc);
        end
        checkOutput({phase, ":frameCount"}, actFrame.size(), expFrame.size());
        n = (actFrame.size() < expFrame.size()) ? actFrame.size() : expFrame.size();
        for (int i = 0; i < n; i++) checkOutput({phase, ":frameCycle"}, actFrame[i], expFrame[i]);
        checkOutput({phase, ":errShort"}, 32'(bus.ERR_SHORT), 32'(mErrShort));
        checkOutput({phase, ":errLong"}, 32'(bus.ERR_LONG), 32'(mErrLong));
        checkOutput({phase, ":dispBank"}, 32'(bus.FB_DISP_BANK), 32'(mdisp));
        expQ.delete(); actQ.delete(); expFrame.delete(); actFrame.delete();
    endtask

    initial begin
        rst          = 1'b1;
        bus.LCD_EN   = 1'b0;
        bus.PPU_MODE = H_BLANK;
        bus.PX_valid = 1'b0;
        bus.PX_IN    = 2'd0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst:we", 32'(bus.FB_WE), 0);
        checkOutput("rst:addr", 32'(bus.FB_ADDR), 0);
        checkOutput("rst:data", 32'(bus.FB_DATA), 0);
        checkOutput("rst:flags", 32'({bus.FRAME_DONE, bus.ERR_SHORT, bus.ERR_LONG, bus.FB_DISP_BANK}), 0);
        rst = 1'b0;
        repeat (3) applyStimulus(1, H_BLANK, 0, 2'd0);

        // One clean line of the 0,1,2,3 pattern.
        runLine(H_PIX_C, 0, 0, H_BLANK);
        settle();
        checkOutput("line0:firstData", (actQ.size() > 0) ? 32'(actQ[0].data) : 32'hFFFF_FFFF, 32'h1B);
        compareAll("line0");

        // Rest of frame 1 with random colours and idle gaps.
        for (int l = 1; l < V_PIX_C; l++) runLine(H_PIX_C, 2, 12, H_BLANK);
        endFrame();
        settle();
        checkOutput("frame1:lastAddr",
                    (actQ.size() > 0) ? 32'(actQ[actQ.size() - 1].addr) : 32'hFFFF_FFFF, 32'd5759);
        compareAll("frame1");

        // Frame 2 in bank 1: short line, long line, random-length line.
        runLine(158, 1, 10, H_BLANK);
        settle();
        checkOutput("short:firstAddr", (actQ.size() > 0) ? 32'(actQ[0].addr) : 32'hFFFF_FFFF, 32'h2000);
        checkOutput("short:lastData",
                    (actQ.size() > 0) ? 32'(actQ[actQ.size() - 1].data) : 32'hFFFF_FFFF, 32'hF0);
        checkOutput("short:errShort", 32'(bus.ERR_SHORT), 1);
        compareAll("short");

        runLine(165, 2, 10, H_BLANK);
        settle();
        checkOutput("long:writes", actQ.size(), 40);
        checkOutput("long:firstAddr", (actQ.size() > 0) ? 32'(actQ[0].addr) : 32'hFFFF_FFFF, 32'h2000 + 40);
        checkOutput("long:errLong", 32'(bus.ERR_LONG), 1);
        compareAll("long");

        runLine($urandom_range(170, 1), 2, 10, H_BLANK);
        settle();
        compareAll("randLen");

        // LCD off mid-line: completed bytes stand, the partial byte is discarded.
        for (int i = 0; i < 10; i++) begin
            logic [1:0] p;
            p = 2'($urandom);
            applyStimulus(1, DRAW, 1, p);
            modelPixel(p, lastCyc);
        end
        applyStimulus(0, DRAW, 0, 2'd0);
        modelEmit(0, lastCyc);
        mx = 0;
        my = 0;
        repeat (6) applyStimulus(0, 2'($urandom), 1'($urandom), 2'($urandom));
        settle();
        compareAll("lcdOff");
        repeat (3) applyStimulus(1, H_BLANK, 0, 2'd0);
        runLine(40, 2, 10, H_BLANK);
        settle();
        checkOutput("reEnable:firstAddr", (actQ.size() > 0) ? 32'(actQ[0].addr) : 32'hFFFF_FFFF, 32'h2000);
        compareAll("reEnable");

        // Partial line closed straight into V_BLANK, then a line in the other bank.
        runLine(37, 2, 10, V_BLANK);
        settle();
        compareAll("drawToVblank");
        runLine(12, 2, 0, H_BLANK);
        settle();
        compareAll("bank0");

        // Async reset while a write strobe is high.
        for (int i = 0; i < 4; i++) applyStimulus(1, DRAW, 1, 2'($urandom));
        checkOutput("preRst:we", 32'(bus.FB_WE), 1);
        rst = 1'b1;
        #1;
        checkOutput("asyncRst:we", 32'(bus.FB_WE), 0);
        checkOutput("asyncRst:addr", 32'(bus.FB_ADDR), 0);
        checkOutput("asyncRst:data", 32'(bus.FB_DATA), 0);
        checkOutput("asyncRst:errs", 32'({bus.ERR_SHORT, bus.ERR_LONG}), 0);
        checkOutput("asyncRst:bank", 32'({bus.FB_DISP_BANK, bus.FRAME_DONE}), 0);
        bus.PPU_MODE = H_BLANK;
        bus.PX_valid = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        rst = 1'b0;
        repeat (3) applyStimulus(1, H_BLANK, 0, 2'd0);
        runLine(30, 2, 10, H_BLANK);
        settle();
        checkOutput("postRst:firstAddr", (actQ.size() > 0) ? 32'(actQ[0].addr) : 32'hFFFF_FFFF, 32'h0000);
        compareAll("postRst");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
